// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fetch_pkg                                                    |
// | Description : Shared types and constants for the fetch sequencer: state   |
// |               encoding, instruction/PC widths and the PC step.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  localparam int INST_SIZE      = 24;
  localparam int PC_W           = INST_SIZE + 8;
  localparam int CNT_W          = 16;
  localparam int PC_STEP        = 4;
  // Wrong-path slots squashed per redirect (entry cycle + REDIRECT cycle).
  localparam int REDIRECT_SLOTS = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    REDIRECT = 3'd2,
    STALL    = 3'd3,
    HALT     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : fetch_sequencer_if                                           |
// | Description : Control bundle between the fetch sequencer and its           |
// |               neighbours (hazard unit, decode, execute, fetch stage).      |
// |   master : sequencer side - takes start/branch/jump/stall/halt requests,   |
// |            drives pcWrEn/newPc, IF/ID flush/stall, halted and counters.    |
// |   slave  : environment side - the mirror image.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fetch_sequencer_if #(
  parameter int PC_W  = fetch_pkg::PC_W,
  parameter int CNT_W = fetch_pkg::CNT_W
);

  logic             start;
  logic             brTaken;
  logic [PC_W-1:0]  brTarget;
  logic             jmpValid;
  logic [PC_W-1:0]  jmpTarget;
  logic             hazardStall;
  logic             haltDetect;
  logic             pcWrEn;
  logic [PC_W-1:0]  newPc;
  logic             ifidFlush;
  logic             ifidStall;
  logic             halted;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] redirCnt;

  modport master (
    input  start, brTaken, brTarget, jmpValid, jmpTarget, hazardStall, haltDetect,
    output pcWrEn, newPc, ifidFlush, ifidStall, halted, stallCnt, redirCnt
  );

  modport slave (
    output start, brTaken, brTarget, jmpValid, jmpTarget, hazardStall, haltDetect,
    input  pcWrEn, newPc, ifidFlush, ifidStall, halted, stallCnt, redirCnt
  );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_counter                                                  |
// | Description : Up-counter that sticks at all-ones instead of wrapping.      |
// |   clk   : clock, rising edge                                               |
// |   reset : asynchronous, active-low                                         |
// |   inc   : count one event this cycle                                       |
// |   clear : synchronous clear (wins over inc)                                |
// |   count : current value                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             inc,
  input  wire logic             clear,
  output logic      [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_sequencer                                              |
// | Description : Fetch-stage control. Each cycle chooses free-run (+4),       |
// |               replay or redirect, arbitrating execute branches, decode     |
// |               jumps, hazard stalls and halt; drives IF/ID flush/stall.     |
// |   clk   : clock, rising edge                                               |
// |   reset : asynchronous, active-low                                         |
// |   bus   : fetch_sequencer_if.master (requests in, fetch controls and       |
// |           performance counters out)                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int INST_SIZE = fetch_pkg::INST_SIZE,
  parameter int PC_W      = INST_SIZE + 8,
  parameter int CNT_W     = fetch_pkg::CNT_W
) (
  input wire logic          clk,
  input wire logic          reset,
  fetch_sequencer_if.master bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [PC_W-1:0]  r_tgt;
  logic [PC_W-1:0]  w_tgt_next;
  logic [PC_W-1:0]  r_pc_track;
  logic             r_pc_wren_d;

  logic             w_pc_wren;
  logic [PC_W-1:0]  w_new_pc;
  logic             w_flush;
  logic             w_stall;
  logic             w_halted;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_redir_cnt;

  // State register plus the local mirror of the fetch PC. Fetch applies
  // newPc one cycle after pcWrEn, so the mirror uses the delayed enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tgt       <= '0;
      r_pc_track  <= '0;
      r_pc_wren_d <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_tgt       <= w_tgt_next;
      r_pc_wren_d <= w_pc_wren;
      r_pc_track  <= r_pc_wren_d ? w_new_pc : (r_pc_track + PC_W'(PC_STEP));
    end
  end

  // Next state and the held target. Branch beats jump (older instruction).
  always_comb begin
    w_next_state = r_state;
    w_tgt_next   = r_tgt;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next_state = RUN;
      end
      RUN: begin
        if (bus.brTaken) begin
          w_next_state = REDIRECT;
          w_tgt_next   = bus.brTarget;
        end else if (bus.jmpValid) begin
          w_next_state = REDIRECT;
          w_tgt_next   = bus.jmpTarget;
        end else if (bus.haltDetect) begin
          w_next_state = HALT;
          w_tgt_next   = r_pc_track;
        end else if (bus.hazardStall) begin
          w_next_state = STALL;
          w_tgt_next   = r_pc_track;
        end
      end
      REDIRECT: begin
        w_next_state = RUN;
      end
      STALL: begin
        if (bus.brTaken) begin
          w_next_state = REDIRECT;
          w_tgt_next   = bus.brTarget;
        end else if (!bus.hazardStall) begin
          w_next_state = RUN;
        end
      end
      HALT: begin
        w_next_state = HALT;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output decode. While reset is low every output is forced to zero so an
  // in-flight redirect or stall is dropped immediately.
  always_comb begin
    w_pc_wren = 1'b0;
    w_new_pc  = '0;
    w_flush   = 1'b0;
    w_stall   = 1'b0;
    w_halted  = 1'b0;
    if (reset) begin
      case (r_state)
        IDLE: begin
          w_pc_wren = 1'b1;
          w_flush   = 1'b1;
        end
        RUN: begin
          if (bus.brTaken) begin
            w_pc_wren = 1'b1;
            w_new_pc  = bus.brTarget;
            w_flush   = 1'b1;
          end else if (bus.jmpValid) begin
            w_pc_wren = 1'b1;
            w_new_pc  = bus.jmpTarget;
            w_flush   = 1'b1;
          end else if (bus.haltDetect) begin
            w_pc_wren = 1'b1;
            w_new_pc  = r_pc_track;
          end else if (bus.hazardStall) begin
            w_pc_wren = 1'b1;
            w_new_pc  = r_pc_track;
            w_stall   = 1'b1;
          end
        end
        REDIRECT: begin
          // Second wrong-path slot; newPc held for the fetch's late apply.
          w_new_pc = r_tgt;
          w_flush  = 1'b1;
        end
        STALL: begin
          if (bus.brTaken) begin
            w_pc_wren = 1'b1;
            w_new_pc  = bus.brTarget;
            w_flush   = 1'b1;
          end else begin
            // IF/ID is held only while the hazard persists; the exit cycle
            // releases it while newPc still covers the pending override.
            w_pc_wren = bus.hazardStall;
            w_new_pc  = r_tgt;
            w_stall   = bus.hazardStall;
          end
        end
        HALT: begin
          w_pc_wren = 1'b1;
          w_new_pc  = r_tgt;
          w_flush   = 1'b1;
          w_halted  = 1'b1;
        end
        default: begin
          w_pc_wren = 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (r_state == STALL),
    .clear (1'b0),
    .count (w_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (r_state == REDIRECT),
    .clear (1'b0),
    .count (w_redir_cnt)
  );

  assign bus.pcWrEn    = w_pc_wren;
  assign bus.newPc     = w_new_pc;
  assign bus.ifidFlush = w_flush;
  assign bus.ifidStall = w_stall;
  assign bus.halted    = w_halted;
  assign bus.stallCnt  = w_stall_cnt;
  assign bus.redirCnt  = w_redir_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_sequencer                                           |
// | Description : Directed bench for fetch_sequencer. Stimulus queues expected |
// |               per-cycle values; a negedge monitor pops and compares. A     |
// |               small fetch-stage model mirrors how fetch consumes newPc.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam int c_pc_w  = 32;
  localparam int c_cnt_w = 16;

  typedef enum int {K_WREN, K_NPC, K_FLUSH, K_STALL, K_HALT, K_SCNT, K_RCNT, K_FPC} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic clk = 1'b0;
  logic reset = 1'b0;

  fetch_sequencer_if #(.PC_W(c_pc_w), .CNT_W(c_cnt_w)) bus ();

  fetch_sequencer #(.INST_SIZE(24), .PC_W(c_pc_w), .CNT_W(c_cnt_w)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Fetch-stage model: registers pcWrEn, then loads newPc on the next edge.
  logic        r_fwren_d;
  logic [31:0] r_fpc;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fwren_d <= 1'b0;
      r_fpc     <= '0;
    end else begin
      r_fwren_d <= bus.pcWrEn;
      r_fpc     <= r_fwren_d ? bus.newPc : r_fpc + 32'd4;
    end
  end

  function automatic logic [31:0] actual(kind_t k);
    case (k)
      K_WREN:  return {31'd0, bus.pcWrEn};
      K_NPC:   return bus.newPc;
      K_FLUSH: return {31'd0, bus.ifidFlush};
      K_STALL: return {31'd0, bus.ifidStall};
      K_HALT:  return {31'd0, bus.halted};
      K_SCNT:  return {16'd0, bus.stallCnt};
      K_RCNT:  return {16'd0, bus.redirCnt};
      default: return r_fpc;
    endcase
  endfunction

  function automatic string kname(kind_t k);
    case (k)
      K_WREN:  return "pcWrEn";
      K_NPC:   return "newPc";
      K_FLUSH: return "ifidFlush";
      K_STALL: return "ifidStall";
      K_HALT:  return "halted";
      K_SCNT:  return "stallCnt";
      K_RCNT:  return "redirCnt";
      default: return "fetchPc";
    endcase
  endfunction

  // Monitor: compare every queued expectation that falls due this cycle.
  chk_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e   = sb.pop_front();
      m_act = actual(m_e.kind);
      n_checks++;
      if (m_e.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s stale-check due_cyc=%0d now=%0d", kname(m_e.kind), m_e.cyc, cyc);
      end else if (m_act !== m_e.exp) begin
        n_errors++;
        $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", kname(m_e.kind), cyc, m_act, m_e.exp);
      end
    end
  end

  // Insert keeping the queue ordered by due cycle.
  task automatic chk_in(int d, kind_t k, logic [31:0] v);
    chk_t e;
    int   i;
    e.cyc  = cyc + d;
    e.kind = k;
    e.exp  = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic chk(kind_t k, logic [31:0] v);
    chk_in(0, k, v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0; bus.brTaken = 1'b0; bus.brTarget = '0;
    bus.jmpValid = 1'b0; bus.jmpTarget = '0;
    bus.hazardStall = 1'b0; bus.haltDetect = 1'b0;

    // Reset held: everything zero.
    tick(); // 1
    chk(K_WREN, 0); chk(K_NPC, 0); chk(K_FLUSH, 0); chk(K_STALL, 0);
    chk(K_HALT, 0); chk(K_SCNT, 0); chk(K_RCNT, 0);
    tick(); // 2 IDLE parks fetch at 0
    reset = 1'b1;
    chk(K_WREN, 1); chk(K_NPC, 0); chk(K_FLUSH, 1);
    tick(); // 3
    bus.start = 1'b1;
    chk(K_WREN, 1);
    tick(); // 4 RUN
    bus.start = 1'b0;
    chk(K_WREN, 0); chk(K_FLUSH, 0);
    tick(); chk(K_FPC, 32'h0);  // 5
    tick(); chk(K_FPC, 32'h4);  // 6
    tick(); chk(K_FPC, 32'h8);  // 7
    tick();                     // 8
    tick(); // 9 branch at PC 0x10
    bus.brTaken = 1'b1; bus.brTarget = 32'h80;
    chk(K_FPC, 32'h10); chk(K_WREN, 1); chk(K_NPC, 32'h80); chk(K_FLUSH, 1);
    tick(); // 10 REDIRECT: target held even though brTarget moves
    bus.brTaken = 1'b0; bus.brTarget = 32'h999;
    chk(K_WREN, 0); chk(K_NPC, 32'h80); chk(K_FLUSH, 1); chk(K_FPC, 32'h14);
    tick(); // 11
    chk(K_FLUSH, 0); chk(K_WREN, 0); chk(K_RCNT, 1); chk(K_FPC, 32'h80);
    tick(); chk(K_FPC, 32'h84); // 12
    tick(); // 13 jump to 0x20
    bus.jmpValid = 1'b1; bus.jmpTarget = 32'h20;
    chk(K_WREN, 1); chk(K_NPC, 32'h20); chk(K_FLUSH, 1); chk(K_FPC, 32'h88);
    tick(); // 14
    bus.jmpValid = 1'b0;
    chk(K_NPC, 32'h20); chk(K_FLUSH, 1); chk(K_WREN, 0);
    tick(); // 15 hazard for 3 cycles at PC 0x20
    bus.hazardStall = 1'b1;
    chk(K_FPC, 32'h20); chk(K_RCNT, 2); chk(K_WREN, 1); chk(K_NPC, 32'h20);
    chk(K_STALL, 1); chk(K_FLUSH, 0);
    tick(); // 16
    chk(K_WREN, 1); chk(K_NPC, 32'h20); chk(K_STALL, 1); chk(K_FPC, 32'h24);
    tick(); // 17
    chk(K_STALL, 1); chk(K_FPC, 32'h20); chk(K_SCNT, 1);
    tick(); // 18 hazard released
    bus.hazardStall = 1'b0;
    chk(K_WREN, 0); chk(K_STALL, 0); chk(K_NPC, 32'h20); chk(K_FPC, 32'h20);
    tick(); // 19
    chk(K_STALL, 0); chk(K_WREN, 0); chk(K_SCNT, 3); chk(K_FPC, 32'h20);
    tick(); chk(K_FPC, 32'h24); // 20
    tick(); // 21 branch and jump together
    bus.brTaken = 1'b1; bus.brTarget = 32'h100;
    bus.jmpValid = 1'b1; bus.jmpTarget = 32'h200;
    chk(K_NPC, 32'h100); chk(K_WREN, 1); chk(K_FLUSH, 1); chk(K_FPC, 32'h28);
    tick(); // 22 jump still high during REDIRECT: ignored
    bus.brTaken = 1'b0;
    chk(K_NPC, 32'h100); chk(K_WREN, 0); chk(K_FLUSH, 1);
    tick(); // 23
    bus.jmpValid = 1'b0;
    chk(K_RCNT, 3); chk(K_FPC, 32'h100); chk(K_WREN, 0);
    tick(); chk(K_FPC, 32'h104); // 24
    tick(); // 25 stall entry
    bus.hazardStall = 1'b1;
    chk(K_FPC, 32'h108); chk(K_STALL, 1); chk(K_NPC, 32'h108);
    tick(); // 26 branch beats stall
    bus.brTaken = 1'b1; bus.brTarget = 32'h300;
    chk(K_WREN, 1); chk(K_NPC, 32'h300); chk(K_FLUSH, 1); chk(K_STALL, 0);
    tick(); // 27
    bus.brTaken = 1'b0; bus.hazardStall = 1'b0;
    chk(K_NPC, 32'h300); chk(K_FLUSH, 1); chk(K_WREN, 0);
    tick(); // 28
    chk(K_SCNT, 4); chk(K_RCNT, 4); chk(K_FPC, 32'h300); chk(K_STALL, 0);
    tick(); chk(K_FPC, 32'h304); // 29
    tick(); // 30 jump to 0x40
    bus.jmpValid = 1'b1; bus.jmpTarget = 32'h40;
    chk(K_FPC, 32'h308);
    tick(); bus.jmpValid = 1'b0; // 31
    tick(); // 32 halt at 0x40
    bus.haltDetect = 1'b1;
    chk(K_FPC, 32'h40); chk(K_WREN, 1); chk(K_NPC, 32'h40); chk(K_HALT, 0); chk(K_RCNT, 5);
    tick(); // 33
    bus.haltDetect = 1'b0;
    chk(K_HALT, 1); chk(K_WREN, 1); chk(K_NPC, 32'h40); chk(K_FLUSH, 1);
    tick(); bus.start = 1'b1; // 34, start must be ignored
    repeat (6) tick(); // 40
    chk(K_HALT, 1); chk(K_NPC, 32'h40); chk(K_FPC, 32'h40); chk(K_WREN, 1);
    tick(); // 41 reset out of HALT
    reset = 1'b0; bus.start = 1'b0;
    chk(K_WREN, 0); chk(K_NPC, 0); chk(K_FLUSH, 0); chk(K_HALT, 0);
    chk(K_SCNT, 0); chk(K_RCNT, 0); chk(K_STALL, 0);
    tick(); // 42
    reset = 1'b1;
    chk(K_WREN, 1); chk(K_FLUSH, 1); chk(K_HALT, 0); chk(K_NPC, 0);
    tick(); bus.start = 1'b1; // 43
    tick(); bus.start = 1'b0; chk(K_WREN, 0); // 44
    tick(); chk(K_FPC, 32'h0); // 45
    tick(); chk(K_FPC, 32'h4); // 46
    tick(); // 47 branch, then reset during REDIRECT
    bus.brTaken = 1'b1; bus.brTarget = 32'h500;
    chk(K_FPC, 32'h8); chk(K_NPC, 32'h500);
    tick(); // 48 async reset mid-cycle
    bus.brTaken = 1'b0; reset = 1'b0;
    chk(K_WREN, 0); chk(K_NPC, 0); chk(K_FLUSH, 0);
    tick(); // 49
    reset = 1'b1;
    chk(K_WREN, 1); chk(K_NPC, 0); chk(K_FLUSH, 1); chk(K_RCNT, 0);
    tick(); bus.start = 1'b1; chk(K_RCNT, 0); // 50
    tick(); bus.start = 1'b0; // 51 RUN
    tick(); // 52 long stall to saturate stallCnt
    bus.hazardStall = 1'b1;
    chk_in(65535, K_SCNT, 32'hFFFE);
    chk_in(65536, K_SCNT, 32'hFFFF);
    chk_in(65541, K_SCNT, 32'hFFFF);
    chk_in(65541, K_STALL, 1);
    repeat (65545) tick();
    bus.hazardStall = 1'b0;
    tick(); tick();
    chk(K_SCNT, 32'hFFFF); chk(K_STALL, 0);
    repeat (3) tick();

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard-drain actual=%0d pending required=0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
